dcache_nb: RTL and testbench

- Parametrised, non-blocking, N-way set-associative data cache controller with integrated tag/data storage and a miss-status (MSHR) table.
- Sits between the LSQ and Dmem. Successor to the direct-mapped/2-way dcache + dcachemem pair, generalised in set count, associativity and number of outstanding misses.
- Write-through, write-allocate. Hits return data the same cycle; misses return a memory ticket and complete later, tagged.

---
 rtl/dcache_nb_if.sv | 30 +++
 rtl/dcache_nb.sv | 174 +++++++++++++++++
 tb/tb_dcache_nb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_nb_if.sv
// rtl/dcache_nb_if.sv - LSQ/Dmem bus bundle for the non-blocking data cache
interface dcache_nb_if;
    logic [1:0]  proc2Dcache_command;
    logic [63:0] proc2Dcache_addr;
    logic [63:0] proc2Dcache_data;
    logic [3:0]  Dmem2Dcache_response;
    logic [3:0]  Dmem2Dcache_tag;
    logic [63:0] Dmem2Dcache_data;
    logic [1:0]  Dcache2Dmem_command;
    logic [63:0] Dcache2Dmem_addr;
    logic [63:0] Dcache2Dmem_data;
    logic        Dcache2proc_valid;
    logic [63:0] Dcache2proc_data;
    logic [3:0]  Dcache2proc_response;
    logic [3:0]  Dcache2proc_tag;

    modport slave (
        input  proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data,
        input  Dmem2Dcache_response, Dmem2Dcache_tag, Dmem2Dcache_data,
        output Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
        output Dcache2proc_valid, Dcache2proc_data, Dcache2proc_response, Dcache2proc_tag
    );

    modport master (
        output proc2Dcache_command, proc2Dcache_addr, proc2Dcache_data,
        output Dmem2Dcache_response, Dmem2Dcache_tag, Dmem2Dcache_data,
        input  Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data,
        input  Dcache2proc_valid, Dcache2proc_data, Dcache2proc_response, Dcache2proc_tag
    );
endinterface

// File: rtl/dcache_nb.sv
// rtl/dcache_nb.sv - non-blocking N-way write-through data cache with MSHR table
module dcache_nb #(
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 2,
    parameter int MSHR_DEPTH = 8,
    parameter int ADDR_BITS  = 16
) (
    input  logic  clock,
    input  logic  reset,
    dcache_nb_if.slave bus
);
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS - 3;
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int MI_BITS  = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;
    typedef logic [WAY_BITS-1:0] way_t;
    typedef logic [MI_BITS-1:0]  mi_t;

    logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
    tag_t                  r_tag   [NUM_SETS][NUM_WAYS];
    logic [63:0]           r_data  [NUM_SETS][NUM_WAYS];
    way_t                  r_ptr   [NUM_SETS];
    logic [MSHR_DEPTH-1:0] r_m_valid;
    logic [MSHR_DEPTH-1:0] r_m_stale;
    logic [3:0]            r_m_ticket [MSHR_DEPTH];
    idx_t                  r_m_idx    [MSHR_DEPTH];
    tag_t                  r_m_tag    [MSHR_DEPTH];

    function automatic way_t ptr_next(input way_t p);
        return (NUM_WAYS == 1) ? '0 : p + way_t'(1);
    endfunction

    // Lowest-numbered invalid way wins; only a full set falls back to the pointer.
    function automatic way_t pick_victim(input logic [NUM_WAYS-1:0] v, input way_t p);
        way_t r = p;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!v[w]) r = way_t'(w);
        return r;
    endfunction

    logic        w_load, w_store, w_hit, w_cpl, w_free_found;
    logic        w_miss_req, w_mshr_alloc, w_st_acc, w_st_alloc;
    logic        w_same_set, w_f_present, w_fill;
    idx_t        w_idx, w_f_idx;
    tag_t        w_tag, w_f_tag;
    way_t        w_hit_way, w_st_way, w_f_ptr, w_f_way;
    mi_t         w_cpl_slot, w_free_slot;
    logic [NUM_WAYS-1:0] w_f_valid;
    logic [1:0]  w_cmd;

    always_comb begin
        w_load  = bus.proc2Dcache_command == 2'd1;
        w_store = bus.proc2Dcache_command == 2'd2;
        w_idx   = bus.proc2Dcache_addr[IDX_BITS+2:3];
        w_tag   = bus.proc2Dcache_addr[ADDR_BITS-1:IDX_BITS+3];

        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = way_t'(w);
            end
        end

        w_cpl      = 1'b0;
        w_cpl_slot = '0;
        for (int m = MSHR_DEPTH - 1; m >= 0; m--) begin
            if (r_m_valid[m] && bus.Dmem2Dcache_tag != 4'd0 && r_m_ticket[m] == bus.Dmem2Dcache_tag) begin
                w_cpl      = 1'b1;
                w_cpl_slot = mi_t'(m);
            end
        end

        // The entry retiring this cycle counts as free, so a full table still accepts a miss.
        w_free_found = 1'b0;
        w_free_slot  = '0;
        for (int m = MSHR_DEPTH - 1; m >= 0; m--) begin
            if (!r_m_valid[m] || (w_cpl && w_cpl_slot == mi_t'(m))) begin
                w_free_found = 1'b1;
                w_free_slot  = mi_t'(m);
            end
        end

        w_miss_req   = w_load && !w_hit && w_free_found;
        w_mshr_alloc = w_miss_req && bus.Dmem2Dcache_response != 4'd0;
        w_st_acc     = w_store && bus.Dmem2Dcache_response != 4'd0;
        w_st_alloc   = w_st_acc && !w_hit;
        w_st_way     = w_hit ? w_hit_way : pick_victim(r_valid[w_idx], r_ptr[w_idx]);

        // The fill sees the set as the same-cycle store leaves it.
        w_f_idx     = r_m_idx[w_cpl_slot];
        w_f_tag     = r_m_tag[w_cpl_slot];
        w_same_set  = w_st_alloc && w_f_idx == w_idx;
        w_f_present = 1'b0;
        w_f_valid   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_same_set && w_st_way == way_t'(w)) begin
                w_f_valid[w] = 1'b1;
                if (w_tag == w_f_tag) w_f_present = 1'b1;
            end else begin
                w_f_valid[w] = r_valid[w_f_idx][w];
                if (r_valid[w_f_idx][w] && r_tag[w_f_idx][w] == w_f_tag) w_f_present = 1'b1;
            end
        end
        w_f_ptr = w_same_set ? ptr_next(r_ptr[w_f_idx]) : r_ptr[w_f_idx];
        w_f_way = pick_victim(w_f_valid, w_f_ptr);
        w_fill  = w_cpl && !r_m_stale[w_cpl_slot] && !w_f_present;

        w_cmd = w_store ? 2'd2 : (w_miss_req ? 2'd1 : 2'd0);
    end

    assign bus.Dcache2Dmem_command  = reset ? w_cmd : 2'd0;
    assign bus.Dcache2Dmem_addr     = (reset && w_cmd != 2'd0) ? {bus.proc2Dcache_addr[63:3], 3'b000} : 64'd0;
    assign bus.Dcache2Dmem_data     = (reset && w_store) ? bus.proc2Dcache_data : 64'd0;
    assign bus.Dcache2proc_valid    = reset && w_load && w_hit && !w_cpl;
    assign bus.Dcache2proc_data     = !reset ? 64'd0 :
                                      w_cpl ? bus.Dmem2Dcache_data :
                                      (w_load && w_hit) ? r_data[w_idx][w_hit_way] : 64'd0;
    assign bus.Dcache2proc_response = (reset && (w_store || w_miss_req)) ? bus.Dmem2Dcache_response : 4'd0;
    assign bus.Dcache2proc_tag      = (reset && w_cpl) ? bus.Dmem2Dcache_tag : 4'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
            r_m_valid <= '0;
            r_m_stale <= '0;
        end else begin
            if (w_st_acc) begin
                for (int m = 0; m < MSHR_DEPTH; m++)
                    if (r_m_valid[m] && r_m_idx[m] == w_idx && r_m_tag[m] == w_tag)
                        r_m_stale[m] <= 1'b1;
                if (w_st_alloc) begin
                    r_valid[w_idx][w_st_way] <= 1'b1;
                    r_ptr[w_idx]             <= ptr_next(r_ptr[w_idx]);
                end
            end
            if (w_cpl) r_m_valid[w_cpl_slot] <= 1'b0;
            // Later assignments to the same set deliberately override the store's update.
            if (w_fill) begin
                r_valid[w_f_idx][w_f_way] <= 1'b1;
                r_ptr[w_f_idx]            <= ptr_next(w_f_ptr);
            end
            if (w_mshr_alloc) begin
                r_m_valid[w_free_slot] <= 1'b1;
                r_m_stale[w_free_slot] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if (w_st_acc) begin
                r_data[w_idx][w_st_way] <= bus.proc2Dcache_data;
                if (w_st_alloc) r_tag[w_idx][w_st_way] <= w_tag;
            end
            if (w_fill) begin
                r_data[w_f_idx][w_f_way] <= bus.Dmem2Dcache_data;
                r_tag[w_f_idx][w_f_way]  <= w_f_tag;
            end
            if (w_mshr_alloc) begin
                r_m_ticket[w_free_slot] <= bus.Dmem2Dcache_response;
                r_m_idx[w_free_slot]    <= w_idx;
                r_m_tag[w_free_slot]    <= w_tag;
            end
        end
    end
endmodule

// File: tb/tb_dcache_nb.sv
// tb/tb_dcache_nb.sv - scoreboard bench for dcache_nb (2 ways, 2 MSHR entries)
module tb_dcache_nb;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dcache_nb_if bus ();

    dcache_nb #(.NUM_SETS(16), .NUM_WAYS(2), .MSHR_DEPTH(2), .ADDR_BITS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_addr(input int idx, input int tag);
        return (64'(tag) << 7) | (64'(idx) << 3);
    endfunction

    function automatic logic [63:0] fill_data(input int i);
        return 64'hF000_0000_0000_0000 + 64'(i) * 64'h1111_0101;
    endfunction

    task automatic push(input logic [3:0] tag, input logic [63:0] data);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic set_inputs(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [3:0] mresp, input logic [3:0] mtag, input logic [63:0] mdata);
        bus.proc2Dcache_command  = cmd;
        bus.proc2Dcache_addr     = addr;
        bus.proc2Dcache_data     = wdata;
        bus.Dmem2Dcache_response = mresp;
        bus.Dmem2Dcache_tag      = mtag;
        bus.Dmem2Dcache_data     = mdata;
    endtask

    // One cycle: apply after posedge, sample at negedge, pop the scoreboard on any proc output.
    task automatic drive(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [3:0] mresp, input logic [3:0] mtag, input logic [63:0] mdata);
        exp_t e;
        @(posedge clock);
        #1;
        set_inputs(cmd, addr, wdata, mresp, mtag, mdata);
        @(negedge clock);
        if (bus.Dcache2proc_valid || bus.Dcache2proc_tag != 4'd0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {59'd0, bus.Dcache2proc_valid, bus.Dcache2proc_tag}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_tag", 64'(bus.Dcache2proc_tag), 64'(e.tag));
                check("sb_data", bus.Dcache2proc_data, e.data);
            end
        end
    endtask

    task automatic expect_req(input string name, input logic [1:0] cmd, input logic [3:0] resp);
        check(name, {60'd0, bus.Dcache2Dmem_command, 2'b00}, {60'd0, cmd, 2'b00});
        check(name, 64'(bus.Dcache2proc_response), 64'(resp));
    endtask

    initial begin
        set_inputs(2'd2, mk_addr(1, 6), 64'h55, 4'd1, 4'd0, 64'd0);
        #2;
        check("rst_cmd", 64'(bus.Dcache2Dmem_command), 64'd0);
        check("rst_resp", 64'(bus.Dcache2proc_response), 64'd0);
        check("rst_data", bus.Dcache2Dmem_data, 64'd0);
        #10 reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(2'd2, mk_addr(i, 5 + i), fill_data(i), 4'(i % 15 + 1), 4'd0, 64'd0);
            expect_req("fill_store", 2'd2, 4'(i % 15 + 1));
            if (i == 3) begin
                check("fill_addr", bus.Dcache2Dmem_addr, mk_addr(3, 8));
                check("fill_wdata", bus.Dcache2Dmem_data, fill_data(3));
            end
        end
        push(4'd0, fill_data(2));
        drive(2'd1, mk_addr(2, 7), 64'd0, 4'd9, 4'd0, 64'd0);
        expect_req("hit_norq", 2'd0, 4'd0);

        drive(2'd1, mk_addr(2, 30) | 64'h5, 64'd0, 4'd3, 4'd0, 64'd0);
        expect_req("miss_rq", 2'd1, 4'd3);
        check("miss_addr", bus.Dcache2Dmem_addr, mk_addr(2, 30));
        drive(2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        push(4'd3, 64'hcccc_cccc_cccc_cccc);
        drive(2'd0, 64'd0, 64'd0, 4'd0, 4'd3, 64'hcccc_cccc_cccc_cccc);
        push(4'd0, 64'hcccc_cccc_cccc_cccc);
        drive(2'd1, mk_addr(2, 30), 64'd0, 4'd0, 4'd0, 64'd0);
        expect_req("refill_hit", 2'd0, 4'd0);
        push(4'd0, fill_data(2));
        drive(2'd1, mk_addr(2, 7), 64'd0, 4'd0, 4'd0, 64'd0);

        drive(2'd1, mk_addr(4, 40), 64'd0, 4'd5, 4'd0, 64'd0);
        expect_req("stale_miss", 2'd1, 4'd5);
        drive(2'd2, mk_addr(4, 40), 64'h1212_1212_1212_1212, 4'd6, 4'd0, 64'd0);
        expect_req("stale_store", 2'd2, 4'd6);
        push(4'd5, 64'hAAAA_AAAA_AAAA_AAAA);
        drive(2'd0, 64'd0, 64'd0, 4'd0, 4'd5, 64'hAAAA_AAAA_AAAA_AAAA);
        push(4'd0, 64'h1212_1212_1212_1212);
        drive(2'd1, mk_addr(4, 40), 64'd0, 4'd0, 4'd0, 64'd0);

        drive(2'd1, mk_addr(8, 50), 64'd0, 4'd7, 4'd0, 64'd0);
        expect_req("mshr_a", 2'd1, 4'd7);
        drive(2'd1, mk_addr(9, 51), 64'd0, 4'd8, 4'd0, 64'd0);
        expect_req("mshr_b", 2'd1, 4'd8);
        drive(2'd1, mk_addr(10, 52), 64'd0, 4'd9, 4'd0, 64'd0);
        expect_req("mshr_full", 2'd0, 4'd0);
        push(4'd7, 64'h7777_0000_0000_0007);
        drive(2'd1, mk_addr(10, 52), 64'd0, 4'd9, 4'd7, 64'h7777_0000_0000_0007);
        expect_req("mshr_swap", 2'd1, 4'd9);
        push(4'd8, 64'h8888_0000_0000_0008);
        drive(2'd0, 64'd0, 64'd0, 4'd0, 4'd8, 64'h8888_0000_0000_0008);
        push(4'd9, 64'h9999_0000_0000_0009);
        drive(2'd1, mk_addr(8, 50), 64'd0, 4'd0, 4'd9, 64'h9999_0000_0000_0009);
        check("hit_cpl_valid", 64'(bus.Dcache2proc_valid), 64'd0);
        expect_req("hit_cpl_norq", 2'd0, 4'd0);
        drive(2'd0, 64'd0, 64'd0, 4'd0, 4'd12, 64'hDEAD);
        check("unmatched_tag", 64'(bus.Dcache2proc_tag), 64'd0);
        push(4'd0, 64'h9999_0000_0000_0009);
        drive(2'd1, mk_addr(10, 52), 64'd0, 4'd0, 4'd0, 64'd0);
        push(4'd0, 64'h7777_0000_0000_0007);
        drive(2'd1, mk_addr(8, 50), 64'd0, 4'd0, 4'd0, 64'd0);

        drive(2'd2, mk_addr(6, 60), 64'h60, 4'd1, 4'd0, 64'd0);
        drive(2'd2, mk_addr(6, 61), 64'h61, 4'd2, 4'd0, 64'd0);
        drive(2'd1, mk_addr(6, 11), 64'd0, 4'd0, 4'd0, 64'd0);
        expect_req("evict_w0", 2'd1, 4'd0);
        push(4'd0, 64'h60);
        drive(2'd1, mk_addr(6, 60), 64'd0, 4'd0, 4'd0, 64'd0);
        drive(2'd2, mk_addr(6, 62), 64'h62, 4'd3, 4'd0, 64'd0);
        drive(2'd1, mk_addr(6, 60), 64'd0, 4'd0, 4'd0, 64'd0);
        expect_req("evict_w1", 2'd1, 4'd0);
        push(4'd0, 64'h61);
        drive(2'd1, mk_addr(6, 61), 64'd0, 4'd0, 4'd0, 64'd0);
        push(4'd0, 64'h62);
        drive(2'd1, mk_addr(6, 62), 64'd0, 4'd0, 4'd0, 64'd0);

        drive(2'd1, mk_addr(12, 70), 64'd0, 4'd10, 4'd0, 64'd0);
        expect_req("sf_miss", 2'd1, 4'd10);
        push(4'd10, 64'hF1F1_F1F1_F1F1_F1F1);
        drive(2'd2, mk_addr(12, 71), 64'h7171, 4'd11, 4'd10, 64'hF1F1_F1F1_F1F1_F1F1);
        expect_req("sf_store", 2'd2, 4'd11);
        push(4'd0, 64'h7171);
        drive(2'd1, mk_addr(12, 71), 64'd0, 4'd0, 4'd0, 64'd0);
        push(4'd0, 64'hF1F1_F1F1_F1F1_F1F1);
        drive(2'd1, mk_addr(12, 70), 64'd0, 4'd0, 4'd0, 64'd0);
        drive(2'd1, mk_addr(12, 17), 64'd0, 4'd0, 4'd0, 64'd0);
        expect_req("sf_evicted", 2'd1, 4'd0);

        drive(2'd1, mk_addr(3, 80), 64'd0, 4'd4, 4'd0, 64'd0);
        expect_req("ar_miss", 2'd1, 4'd4);
        @(posedge clock);
        #1;
        set_inputs(2'd1, mk_addr(3, 81), 64'd0, 4'd2, 4'd0, 64'd0);
        #2 reset = 1'b0;
        #1;
        check("ar_cmd", 64'(bus.Dcache2Dmem_command), 64'd0);
        check("ar_addr", bus.Dcache2Dmem_addr, 64'd0);
        check("ar_resp", 64'(bus.Dcache2proc_response), 64'd0);
        #3 reset = 1'b1;
        drive(2'd0, 64'd0, 64'd0, 4'd0, 4'd4, 64'h4444);
        check("ar_old_tag", 64'(bus.Dcache2proc_tag), 64'd0);
        drive(2'd1, mk_addr(2, 7), 64'd0, 4'd0, 4'd0, 64'd0);
        expect_req("ar_cold_a", 2'd1, 4'd0);
        check("ar_cold_valid", 64'(bus.Dcache2proc_valid), 64'd0);
        drive(2'd1, mk_addr(4, 40), 64'd0, 4'd0, 4'd0, 64'd0);
        expect_req("ar_cold_b", 2'd1, 4'd0);

        drive(2'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
